stream_mux_2x1: RTL

Two-input packet stream multiplexer, the merging counterpart of the team's 1x2 demultiplexer. Two valid/ready source channels share one registered output channel. A round-robin arbiter picks the source, and the grant is locked for a whole packet, delimited by `last`, so packets never interleave. The block sits in front of any single-consumer sink that receives traffic from two producers.

---
 rtl/stream_mux_2x1.sv | 90 +++++++++
 1 files changed

// File: rtl/stream_mux_2x1.sv
// Two-source packet stream mux: round-robin arbitration with the grant held for
// a whole packet (until last), feeding a single-entry registered output stage.
module stream_mux_2x1 #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_valid,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_valid,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_last,
  output logic              out_sel,
  input  logic              out_ready
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  logic [1:0]        state;
  logic              prio;
  logic              can_load;
  logic              g_act;
  logic              g_sel;
  logic              acc;
  logic              acc_last;
  logic [DATA_W-1:0] acc_data;

  // In a locked state the grant is fixed even if the owner is momentarily idle.
  always_comb begin
    g_act = 1'b0;
    g_sel = 1'b0;
    case (state)
      LOCK0: begin g_act = 1'b1; g_sel = 1'b0; end
      LOCK1: begin g_act = 1'b1; g_sel = 1'b1; end
      default: begin
        if (in0_valid && in1_valid) begin
          g_act = 1'b1;
          g_sel = prio;
        end else if (in0_valid) begin
          g_act = 1'b1;
          g_sel = 1'b0;
        end else if (in1_valid) begin
          g_act = 1'b1;
          g_sel = 1'b1;
        end
      end
    endcase
  end

  assign can_load  = !out_valid || out_ready;
  assign in0_ready = !rst && can_load && g_act && !g_sel;
  assign in1_ready = !rst && can_load && g_act &&  g_sel;
  assign acc       = (in0_valid && in0_ready) || (in1_valid && in1_ready);
  assign acc_last  = g_sel ? in1_last : in0_last;
  assign acc_data  = g_sel ? in1_data : in0_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_sel   <= 1'b0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_data  <= acc_data;
      out_last  <= acc_last;
      out_sel   <= g_sel;
      // A last beat always releases the lock and hands priority to the other side.
      if (acc_last) begin
        state <= IDLE;
        prio  <= !g_sel;
      end else begin
        state <= g_sel ? LOCK1 : LOCK0;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
